noc_phase_ctrl: RTL and testbench
=================================

Name: noc_phase_ctrl

Overview:
Synthesizable sequencer that drives the shared router op bus and the global in_cycle counter for the NoC mesh. Each network cycle is issued as LoadStaging -> Phase0 -> Phase1. The block counts network cycles and detects global quiescence from the per-router done flags. It replaces testbench-side sequencing, so the mesh can run under hardware control with pause, completion and timeout.

Parameters:
ROUTERS, 16, number of routers; width of done_vec
CYCLE_W, 16, width of in_cycle
MAX_CYCLES, 1000, timeout limit in network cycles; 0 disables timeout
DONE_HOLD, 2, consecutive network cycles with all routers done required to declare finish (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  level/pulse; begins a run when in IDLE or FIN
pause  in  1  freezes phase advance while high
done_vec  in  ROUTERS  per-router done flags, sampled at end of Phase1
op  out  2  router op: 0=NOP, 1=LoadStaging, 2=Phase0, 3=Phase1
in_cycle  out  CYCLE_W  current network cycle number
cycle_tick  out  1  one-clock pulse when in_cycle increments
busy  out  1  high while a run is active (RUN state)
finished  out  1  sticky; run ended by quiescence
timeout  out  1  sticky; run ended by MAX_CYCLES

Behaviour:
- Reset (async, immediate): state=IDLE, op=0, in_cycle=0, cycle_tick=0, busy=0, finished=0, timeout=0, quiet_cnt=0, last_phase=Phase1.
- All outputs are registered. op changes only on clk rising edge.
- States: IDLE, RUN, FIN.
- IDLE/FIN with start=1 at edge:
  - -> RUN, op<=LoadStaging, last_phase<=LoadStaging.
  - Clear in_cycle, quiet_cnt, finished and timeout; busy<=1.
  - First LoadStaging is therefore visible one clock after start is sampled.
- RUN, pause=0: op <= next(last_phase), where next is Load->Ph0->Ph1->Load; last_phase updated.
- RUN, pause=1: op<=NOP, last_phase held. On resume, issue the phase following last_phase. No phase is skipped or repeated.
- End of network cycle = an edge in RUN, pause=0, last_phase=Phase1 (op is about to become LoadStaging). At that edge, in order:
  - alldone = &done_vec. quiet_cnt <= alldone ? quiet_cnt+1 : 0.
  - If alldone and quiet_cnt+1 == DONE_HOLD: -> FIN, finished<=1, op<=NOP, busy<=0. in_cycle does not increment.
  - Else if MAX_CYCLES!=0 and in_cycle == MAX_CYCLES-1: -> FIN, timeout<=1, op<=NOP, busy<=0. in_cycle holds.
  - Else: in_cycle<=in_cycle+1 (modulo 2^CYCLE_W), cycle_tick<=1, op<=LoadStaging.
- Simultaneous finish and timeout at the same edge: finish wins; timeout stays 0.
- cycle_tick is high for exactly one clock; 0 otherwise.
- start while in RUN: ignored.
- pause in IDLE/FIN: no effect. A start with pause=1 still enters RUN, but op stays NOP until pause drops; the first phase then issued is LoadStaging.
- done_vec is sampled only at end-of-cycle edges. Values at other times are ignored.
- quiet_cnt width is clog2(DONE_HOLD+1), saturating.
- FIN holds op=NOP and keeps in_cycle, finished and timeout until start or rst.
- rst mid-run: immediate return to reset values; op drops to NOP asynchronously.
- Period without pause: op sequence 1,2,3 repeating. in_cycle advances every 3 clocks.

Test Plan:
- Reset/idle: assert rst, hold start=0 for 10 clks -> op=0, in_cycle=0, busy=0, finished=0, timeout=0 throughout.
- Basic sequencing: start pulse, done_vec=0 -> op after start is 1,2,3,1,2,3…; in_cycle = 0,0,0,1,1,1,2…; cycle_tick pulses with each in_cycle increment; busy=1.
- Quiescence: DONE_HOLD=2; set done_vec all-ones during network cycle 4 -> checks at end of cycles 4 and 5; finished=1 with in_cycle=5, op=0, busy=0, timeout=0. Repeat with one bit low in cycle 5 -> quiet_cnt resets and the run continues.
- Timeout: MAX_CYCLES=8, done_vec=0 -> after the Phase1 of in_cycle 7: timeout=1, in_cycle=7, op=0. A new start pulse clears timeout and op resumes with 1 and in_cycle=0.
- Pause: assert pause for 4 clks immediately after op=2 -> op=0 for 4 clks, then op=3, then 1; in_cycle unchanged during the pause.
- Async reset mid-run: pulse rst between clock edges during op=3, in_cycle=5 -> op=0 and in_cycle=0 immediately (before the next edge); start ignored while rst=1.

Source files
------------

// File: rtl/noc_phase_ctrl.sv
// noc_phase_ctrl: sequences the shared router op bus (LoadStaging -> Phase0 ->
// Phase1), counts network cycles, and ends a run on global quiescence or on a
// cycle-count timeout. All outputs are registered.
module noc_phase_ctrl #(
  parameter int unsigned ROUTERS    = 16,
  parameter int unsigned CYCLE_W    = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned DONE_HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic [ROUTERS-1:0] done_vec,
  output logic [1:0]         op,
  output logic [CYCLE_W-1:0] in_cycle,
  output logic               cycle_tick,
  output logic               busy,
  output logic               finished,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_PH0  = 2'd2,
    OP_PH1  = 2'd3
  } op_t;

  localparam int unsigned        QW       = $clog2(DONE_HOLD + 1);
  localparam logic [QW:0]        HOLD_V   = (QW + 1)'(DONE_HOLD);
  localparam int unsigned        LAST_I   = (MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1;
  localparam logic [CYCLE_W-1:0] LAST_CYC = CYCLE_W'(LAST_I);
  localparam bit                 TO_EN    = (MAX_CYCLES != 0);

  state_t             state_q, state_n;
  op_t                op_q, op_n;
  op_t                last_q, last_n;
  logic [CYCLE_W-1:0] cyc_q, cyc_n;
  logic               tick_q, tick_n;
  logic               busy_q, busy_n;
  logic               fin_q, fin_n;
  logic               to_q, to_n;
  logic [QW-1:0]      quiet_q, quiet_n;

  logic [QW:0]        quiet_inc;
  logic [QW-1:0]      quiet_sat;
  logic               alldone;

  function automatic op_t next_phase(input op_t p);
    case (p)
      OP_LOAD: next_phase = OP_PH0;
      OP_PH0:  next_phase = OP_PH1;
      default: next_phase = OP_LOAD;
    endcase
  endfunction

  // State and output registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      last_q  <= OP_PH1;
      cyc_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      to_q    <= 1'b0;
      quiet_q <= '0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      last_q  <= last_n;
      cyc_q   <= cyc_n;
      tick_q  <= tick_n;
      busy_q  <= busy_n;
      fin_q   <= fin_n;
      to_q    <= to_n;
      quiet_q <= quiet_n;
    end
  end

  // Next-state logic: phase advance, end-of-network-cycle bookkeeping, run end.
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    last_n    = last_q;
    cyc_n     = cyc_q;
    tick_n    = 1'b0;
    busy_n    = busy_q;
    fin_n     = fin_q;
    to_n      = to_q;
    quiet_n   = quiet_q;
    alldone   = &done_vec;
    quiet_inc = {1'b0, quiet_q} + 1'b1;
    quiet_sat = (quiet_inc >= HOLD_V) ? HOLD_V[QW-1:0] : quiet_inc[QW-1:0];

    case (state_q)
      S_IDLE, S_FIN: begin
        op_n = OP_NOP;
        if (start) begin
          state_n = S_RUN;
          busy_n  = 1'b1;
          cyc_n   = '0;
          quiet_n = '0;
          fin_n   = 1'b0;
          to_n    = 1'b0;
          // Starting while paused parks last_phase at NOP so that resuming
          // issues LoadStaging without running end-of-cycle bookkeeping.
          if (pause) begin
            op_n   = OP_NOP;
            last_n = OP_NOP;
          end else begin
            op_n   = OP_LOAD;
            last_n = OP_LOAD;
          end
        end
      end
      S_RUN: begin
        if (pause) begin
          op_n = OP_NOP;
        end else if (last_q == OP_PH1) begin
          quiet_n = alldone ? quiet_sat : '0;
          if (alldone && (quiet_inc == HOLD_V)) begin
            state_n = S_FIN;
            fin_n   = 1'b1;
            op_n    = OP_NOP;
            busy_n  = 1'b0;
          end else if (TO_EN && (cyc_q == LAST_CYC)) begin
            state_n = S_FIN;
            to_n    = 1'b1;
            op_n    = OP_NOP;
            busy_n  = 1'b0;
          end else begin
            cyc_n  = cyc_q + 1'b1;
            tick_n = 1'b1;
            op_n   = OP_LOAD;
            last_n = OP_LOAD;
          end
        end else begin
          op_n   = next_phase(last_q);
          last_n = next_phase(last_q);
        end
      end
      default: begin
        state_n = S_IDLE;
        op_n    = OP_NOP;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign op         = op_q;
  assign in_cycle   = cyc_q;
  assign cycle_tick = tick_q;
  assign busy       = busy_q;
  assign finished   = fin_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_noc_phase_ctrl.sv
// Testbench for noc_phase_ctrl: directed stimulus, a phase-count model checked
// every clock, and literal expectations at key points of each scenario.
module tb_noc_phase_ctrl;

  localparam int R    = 4;
  localparam int CW   = 16;
  localparam int MAXC = 8;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [R-1:0]  done_vec = '0;
  logic [1:0]    op;
  logic [CW-1:0] in_cycle;
  logic          cycle_tick, busy, finished, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a run is a count of issued phases; op and in_cycle follow from it.
  bit m_run   = 1'b0;
  int m_issued = 0;
  int m_cyc   = 0;
  int m_quiet = 0;
  bit m_tick  = 1'b0;
  bit m_fin   = 1'b0;
  bit m_to    = 1'b0;
  int m_op    = 0;

  noc_phase_ctrl #(
    .ROUTERS   (R),
    .CYCLE_W   (CW),
    .MAX_CYCLES(MAXC),
    .DONE_HOLD (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .done_vec  (done_vec),
    .op        (op),
    .in_cycle  (in_cycle),
    .cycle_tick(cycle_tick),
    .busy      (busy),
    .finished  (finished),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model update on each clock edge (or immediately on reset).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_issued = 0; m_cyc = 0; m_quiet = 0;
      m_tick = 0; m_fin = 0; m_to = 0; m_op = 0;
    end else begin
      m_tick = 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_cyc = 0; m_quiet = 0; m_fin = 0; m_to = 0;
          if (pause) begin m_issued = 0; m_op = 0; end
          else begin m_issued = 1; m_op = 1; end
        end
      end else if (pause) begin
        m_op = 0;
      end else if (m_issued == 0 || (m_issued % 3) != 0) begin
        m_issued++;
        m_op = ((m_issued - 1) % 3) + 1;
      end else begin
        m_quiet = (&done_vec) ? m_quiet + 1 : 0;
        if ((&done_vec) && m_quiet >= HOLD) begin
          m_run = 0; m_fin = 1; m_op = 0;
        end else if (m_cyc == MAXC - 1) begin
          m_run = 0; m_to = 1; m_op = 0;
        end else begin
          m_issued++;
          m_cyc  = (m_issued - 1) / 3;
          m_tick = 1;
          m_op   = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("op", int'(op), m_op);
    check("in_cycle", int'(in_cycle), m_cyc);
    check("cycle_tick", int'(cycle_tick), int'(m_tick));
    check("busy", int'(busy), int'(m_run));
    check("finished", int'(finished), int'(m_fin));
    check("timeout", int'(timeout), int'(m_to));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to_cycle(input int c);
    int k;
    k = 0;
    while (int'(in_cycle) != c && k < 60) begin step(); k++; end
    check("reach_cycle", int'(in_cycle), c);
  endtask

  task automatic run_to_end();
    int k;
    k = 0;
    while (busy && k < 60) begin step(); k++; end
    check("run_end_busy", int'(busy), 0);
  endtask

  initial begin
    // Reset / idle
    #1 rst = 1'b1;
    repeat (10) step();
    check("rst_op", int'(op), 0);
    check("rst_cycle", int'(in_cycle), 0);
    rst = 1'b0;
    step();
    check("idle_busy", int'(busy), 0);

    // Basic sequencing
    start = 1'b1; step(); start = 1'b0;
    check("seq_op1", int'(op), 1);
    check("seq_busy", int'(busy), 1);
    step(); check("seq_op2", int'(op), 2);
    step(); check("seq_op3", int'(op), 3);
    step();
    check("seq_op4", int'(op), 1);
    check("seq_cyc1", int'(in_cycle), 1);
    check("seq_tick", int'(cycle_tick), 1);
    start = 1'b1; step(); start = 1'b0;
    check("ign_start_op", int'(op), 2);
    check("ign_start_cyc", int'(in_cycle), 1);

    // Quiescence: all done in cycles 4 and 5
    run_to_cycle(4);
    done_vec = '1;
    run_to_end();
    check("q_fin", int'(finished), 1);
    check("q_cyc", int'(in_cycle), 5);
    check("q_op", int'(op), 0);
    check("q_to", int'(timeout), 0);

    // Quiescence broken in cycle 5; finish lands on the timeout cycle
    done_vec = '0;
    start = 1'b1; step(); start = 1'b0;
    check("q2_fin_clr", int'(finished), 0);
    run_to_cycle(4);
    done_vec = '1;
    run_to_cycle(5);
    done_vec = 4'b1011;
    run_to_cycle(6);
    check("q2_busy", int'(busy), 1);
    check("q2_notfin", int'(finished), 0);
    done_vec = '1;
    run_to_end();
    check("q2_fin", int'(finished), 1);
    check("q2_cyc", int'(in_cycle), 7);
    check("q2_to", int'(timeout), 0);

    // Timeout
    done_vec = '0;
    start = 1'b1; step(); start = 1'b0;
    run_to_end();
    check("to_flag", int'(timeout), 1);
    check("to_cyc", int'(in_cycle), 7);
    check("to_op", int'(op), 0);
    check("to_fin", int'(finished), 0);
    start = 1'b1; step(); start = 1'b0;
    check("rs_op", int'(op), 1);
    check("rs_cyc", int'(in_cycle), 0);
    check("rs_to", int'(timeout), 0);

    // Pause right after Phase0
    step(); check("p_op2", int'(op), 2);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("p_nop", int'(op), 0);
      check("p_cyc", int'(in_cycle), 0);
    end
    pause = 1'b0;
    step(); check("p_res3", int'(op), 3);
    step();
    check("p_res1", int'(op), 1);
    check("p_res_cyc", int'(in_cycle), 1);

    // Async reset mid-run at in_cycle 5, op Phase1
    begin
      int k;
      k = 0;
      while (!(op == 2'd3 && in_cycle == 16'd5) && k < 60) begin step(); k++; end
      check("ar_op_pre", int'(op), 3);
      check("ar_cyc_pre", int'(in_cycle), 5);
    end
    #1 rst = 1'b1;
    #1;
    check("ar_op", int'(op), 0);
    check("ar_cyc", int'(in_cycle), 0);
    check("ar_busy", int'(busy), 0);
    start = 1'b1; step();
    check("ar_start_ign", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("ar_idle", int'(busy), 0);

    // Start while paused
    pause = 1'b1; start = 1'b1; step(); start = 1'b0;
    check("sp_busy", int'(busy), 1);
    check("sp_op", int'(op), 0);
    step(); check("sp_hold", int'(op), 0);
    pause = 1'b0;
    step();
    check("sp_op1", int'(op), 1);
    check("sp_cyc", int'(in_cycle), 0);
    check("sp_tick", int'(cycle_tick), 0);
    step(); check("sp_op2", int'(op), 2);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
